onchip_mem_arbiter: RTL

- Two-master Avalon-MM arbiter in front of the single-port 4096x32 on-chip RAM slave (s1).
- Lets the Nios data master (m0) and the Sobel pixel engine (m1) share the one RAM port.
- Each cycle it grants at most one requester and drives the RAM address/byteenable/chipselect/write lines.
- Routes returning read data to the correct master with a fixed one-cycle read latency (RAM address registered, output unregistered).

---
 rtl/onchip_mem_pkg.sv | 14 +
 rtl/onchip_mem_arbiter_if.sv | 28 ++
 rtl/onchip_mem_rr_arb2.sv | 54 +++++
 rtl/onchip_mem_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared constants and master identifiers for the on-chip RAM arbiter slice.
// Pure declarations: no latency, no backpressure.
package onchip_mem_pkg;

    localparam int ONCHIP_ADDR_W = 12;
    localparam int ONCHIP_DATA_W = 32;
    localparam int ONCHIP_BE_W   = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master-to-slave bundle used for each arbiter requester port.
// Latency and backpressure are defined by whoever drives the slave side.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = onchip_mem_pkg::ONCHIP_ADDR_W,
    parameter int DATA_W = onchip_mem_pkg::ONCHIP_DATA_W,
    parameter int BE_W   = onchip_mem_pkg::ONCHIP_BE_W
) ();

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_mem_rr_arb2.sv
// Two-way grant logic: round-robin, or m0 priority with an m1 starvation guard.
// Grant is combinational from requests and registered state; at most one grant per cycle.
module onchip_mem_rr_arb2
    import onchip_mem_pkg::*;
#(
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    master_id_e last_grant;
    master_id_e winner;
    logic [7:0] starve_cnt;
    logic       any_gnt;

    always_comb begin
        winner = M0;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0)
                winner = (starve_cnt == LIMIT) ? M1 : M0;
            else
                winner = (last_grant == M1) ? M0 : M1;
        end else if (req1) begin
            winner = M1;
        end
        // Grants are suppressed during reset so waitrequest reads 1 throughout.
        any_gnt = (req0 | req1) & ~reset;
        gnt0    = any_gnt & (winner == M0);
        gnt1    = any_gnt & (winner == M1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= M1;
            starve_cnt <= 8'd0;
        end else begin
            if (any_gnt)
                last_grant <= winner;
            if (!req1 || gnt1)
                starve_cnt <= 8'd0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port 4096x32 on-chip RAM.
// Latency: write in grant cycle, read data one cycle after grant; backpressure: waitrequest=~grant.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W       = ONCHIP_ADDR_W,
    parameter int DATA_W       = ONCHIP_DATA_W,
    parameter int BE_W         = ONCHIP_BE_W,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BE_W-1:0]       mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic gnt0, gnt1;
    logic rd_pend0, rd_pend1;

    onchip_mem_rr_arb2 #(
        .FIXED_PRIO   (FIXED_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (m0.read | m0.write),
        .req1  (m1.read | m1.write),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (gnt0) begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_writedata  = m0.writedata;
            mem_chipselect = 1'b1;
            mem_write      = m0.write;
        end else if (gnt1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            mem_chipselect = 1'b1;
            mem_write      = m1.write;
        end
    end

    assign mem_clken = 1'b1;

    // A request with both read and write set performs only the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= gnt0 & m0.read & ~m0.write;
            rd_pend1 <= gnt1 & m1.read & ~m1.write;
        end
    end

    assign m0.waitrequest   = ~gnt0;
    assign m1.waitrequest   = ~gnt1;
    assign m0.readdatavalid = rd_pend0;
    assign m1.readdatavalid = rd_pend1;
    assign m0.readdata      = rd_pend0 ? mem_readdata : '0;
    assign m1.readdata      = rd_pend1 ? mem_readdata : '0;

endmodule
